// File: rtl/exc_pkg.sv
// Shared types and constants for the LEGv8 exception control stage.
package exc_pkg;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } exc_state_e;

  localparam logic [3:0] ESR_NONE   = 4'h0;
  localparam logic [3:0] ESR_INVOP  = 4'h1;
  localparam logic [3:0] ESR_IRQ    = 4'h2;
  localparam logic [3:0] ESR_DFAULT = 4'hF;

  localparam logic [1:0] SEL_SEQ  = 2'b00;
  localparam logic [1:0] SEL_BR   = 2'b01;
  localparam logic [1:0] SEL_EXC  = 2'b10;
  localparam logic [1:0] SEL_ERET = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/exc_ctrl.sv
// Exception control: drives next-PC mux select and the ELR/ESR exception state.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned   N          = 64,
  parameter logic [N-1:0]  EXC_VECTOR = 64'h0000_0000_0000_00D8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] pc_i,
  input  logic         branch_i,
  input  logic         exc_req_i,
  input  logic         irq_i,
  input  logic         eret_i,
  output logic [1:0]   pc_sel_o,
  output logic [N-1:0] exc_vector_o,
  output logic [N-1:0] elr_o,
  output logic [3:0]   esr_o,
  output logic         in_handler_o,
  output logic         flush_o,
  output logic [7:0]   exc_cnt_o
);

  exc_state_e   state_q, state_d;
  logic [N-1:0] elr_q, elr_d;
  logic [3:0]   esr_q, esr_d;
  logic         take_exc;

  always_comb begin
    state_d  = state_q;
    elr_d    = elr_q;
    esr_d    = esr_q;
    pc_sel_o = SEL_SEQ;
    flush_o  = 1'b0;
    take_exc = 1'b0;
    if (!reset) begin
      if (exc_req_i) begin
        pc_sel_o = SEL_EXC;
        flush_o  = 1'b1;
        take_exc = 1'b1;
        if (state_q == HANDLER) begin
          // Double fault keeps the original return address.
          esr_d = ESR_DFAULT;
        end else begin
          elr_d   = pc_i;
          esr_d   = ESR_INVOP;
          state_d = HANDLER;
        end
      end else if (irq_i && (state_q == RUN)) begin
        pc_sel_o = SEL_EXC;
        flush_o  = 1'b1;
        take_exc = 1'b1;
        elr_d    = pc_i;
        esr_d    = ESR_IRQ;
        state_d  = HANDLER;
      end else if (eret_i && (state_q == HANDLER)) begin
        pc_sel_o = SEL_ERET;
        flush_o  = 1'b1;
        state_d  = RUN;
      end else if (branch_i) begin
        pc_sel_o = SEL_BR;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      elr_q   <= '0;
      esr_q   <= ESR_NONE;
    end else begin
      state_q <= state_d;
      elr_q   <= elr_d;
      esr_q   <= esr_d;
    end
  end

  sat_counter #(
    .W (8)
  ) u_exc_cnt (
    .clk_i   (clk),
    .reset_i (reset),
    .inc_i   (take_exc),
    .cnt_o   (exc_cnt_o)
  );

  assign exc_vector_o = EXC_VECTOR;
  assign elr_o        = elr_q;
  assign esr_o        = esr_q;
  assign in_handler_o = (state_q == HANDLER);

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed vector table, random run against a model, saturation.
module tb_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        branch, exc_req, irq, eret;
  logic [1:0]  pc_sel;
  logic [63:0] exc_vector, elr;
  logic [3:0]  esr;
  logic        in_handler, flush;
  logic [7:0]  exc_cnt;

  int checks = 0;
  int passes = 0;

  // Reference model state
  bit          m_inh;
  logic [63:0] m_elr;
  logic [3:0]  m_esr;
  int          m_cnt;

  typedef struct {
    logic        rst;
    logic [63:0] pc;
    logic        br, exc, irq, eret;
    logic [1:0]  sel;
    logic        fl, inh;
    logic [63:0] elr;
    logic [3:0]  esr;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[14];

  always #5 clk = ~clk;

  exc_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc_i         (pc),
    .branch_i     (branch),
    .exc_req_i    (exc_req),
    .irq_i        (irq),
    .eret_i       (eret),
    .pc_sel_o     (pc_sel),
    .exc_vector_o (exc_vector),
    .elr_o        (elr),
    .esr_o        (esr),
    .in_handler_o (in_handler),
    .flush_o      (flush),
    .exc_cnt_o    (exc_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Expected outputs from the rules, then advance the model by one edge.
  task automatic model_step(input logic r, input logic [63:0] p, input logic b, input logic x,
                            input logic q, input logic e, output logic [1:0] sel,
                            output logic fl);
    sel = 2'b00;
    fl  = 1'b0;
    if (r) begin
      m_inh = 0; m_elr = '0; m_esr = 4'h0; m_cnt = 0;
    end else if (x || (q && !m_inh)) begin
      sel = 2'b10;
      fl  = 1'b1;
      if (x && m_inh) m_esr = 4'hF;
      else begin
        m_elr = p;
        m_esr = x ? 4'h1 : 4'h2;
        m_inh = 1;
      end
      if (m_cnt < 255) m_cnt = m_cnt + 1;
    end else if (e && m_inh) begin
      sel = 2'b11;
      fl  = 1'b1;
      m_inh = 0;
    end else if (b) begin
      sel = 2'b01;
    end
  endtask

  // Drive one cycle, check comb outputs before the edge and registered ones after.
  task automatic apply(input string tag, input logic r, input logic [63:0] p, input logic b,
                       input logic x, input logic q, input logic e, input logic [1:0] esel,
                       input logic efl, input logic einh, input logic [63:0] eelr,
                       input logic [3:0] eesr, input logic [7:0] ecnt);
    reset = r; pc = p; branch = b; exc_req = x; irq = q; eret = e;
    #1;
    chk({tag, ".pc_sel"}, 64'(pc_sel), 64'(esel));
    chk({tag, ".flush"}, 64'(flush), 64'(efl));
    @(posedge clk);
    #1;
    chk({tag, ".in_handler"}, 64'(in_handler), 64'(einh));
    chk({tag, ".elr"}, elr, eelr);
    chk({tag, ".esr"}, 64'(esr), 64'(eesr));
    chk({tag, ".cnt"}, 64'(exc_cnt), 64'(ecnt));
  endtask

  task automatic model_apply(input string tag, input logic r, input logic [63:0] p,
                             input logic b, input logic x, input logic q, input logic e);
    logic [1:0] s;
    logic       f;
    model_step(r, p, b, x, q, e, s, f);
    apply(tag, r, p, b, x, q, e, s, f, m_inh, m_elr, m_esr, 8'(m_cnt));
  endtask

  initial begin
    logic [1:0] s;
    logic       f;
    vecs[0]  = '{1, 64'h40,  1, 1, 1, 1, 2'b00, 0, 0, 64'h0,   4'h0, 8'd0};
    vecs[1]  = '{1, 64'h40,  1, 1, 1, 1, 2'b00, 0, 0, 64'h0,   4'h0, 8'd0};
    vecs[2]  = '{0, 64'h40,  0, 1, 0, 0, 2'b10, 1, 1, 64'h40,  4'h1, 8'd1};
    vecs[3]  = '{0, 64'h100, 0, 0, 0, 1, 2'b11, 1, 0, 64'h40,  4'h1, 8'd1};
    vecs[4]  = '{0, 64'h104, 1, 0, 0, 1, 2'b01, 0, 0, 64'h40,  4'h1, 8'd1};
    vecs[5]  = '{0, 64'h40,  0, 1, 0, 0, 2'b10, 1, 1, 64'h40,  4'h1, 8'd2};
    vecs[6]  = '{0, 64'h84,  0, 0, 1, 0, 2'b00, 0, 1, 64'h40,  4'h1, 8'd2};
    vecs[7]  = '{0, 64'hE0,  0, 1, 0, 1, 2'b10, 1, 1, 64'h40,  4'hF, 8'd3};
    vecs[8]  = '{0, 64'hD8,  0, 0, 0, 1, 2'b11, 1, 0, 64'h40,  4'hF, 8'd3};
    vecs[9]  = '{0, 64'h300, 0, 1, 1, 0, 2'b10, 1, 1, 64'h300, 4'h1, 8'd4};
    vecs[10] = '{0, 64'hDC,  0, 0, 1, 1, 2'b11, 1, 0, 64'h300, 4'h1, 8'd4};
    vecs[11] = '{0, 64'h304, 0, 0, 1, 0, 2'b10, 1, 1, 64'h304, 4'h2, 8'd5};
    vecs[12] = '{1, 64'h0,   0, 1, 0, 0, 2'b00, 0, 0, 64'h0,   4'h0, 8'd0};
    vecs[13] = '{0, 64'h8,   0, 0, 0, 0, 2'b00, 0, 0, 64'h0,   4'h0, 8'd0};

    reset = 1; pc = '0; branch = 0; exc_req = 0; irq = 0; eret = 0;
    @(posedge clk);
    #1;
    chk("exc_vector", exc_vector, 64'hD8);

    foreach (vecs[i]) begin
      model_step(vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].exc, vecs[i].irq, vecs[i].eret,
                 s, f);
      apply($sformatf("vec%0d", i), vecs[i].rst, vecs[i].pc, vecs[i].br, vecs[i].exc,
            vecs[i].irq, vecs[i].eret, vecs[i].sel, vecs[i].fl, vecs[i].inh, vecs[i].elr,
            vecs[i].esr, vecs[i].cnt);
    end

    for (int i = 0; i < 400; i++) begin
      model_apply($sformatf("rnd%0d", i), ($urandom_range(0, 39) == 0),
                  {$urandom, $urandom}, 1'($urandom), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 3) == 0), 1'($urandom));
    end

    model_apply("sat.reset", 1, 64'h0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      model_apply("sat.irq", 0, 64'(i * 4), 0, 0, 1, 0);
      model_apply("sat.eret", 0, 64'hD8, 0, 0, 0, 1);
    end
    chk("sat.cnt_ff", 64'(exc_cnt), 64'hFF);
    model_apply("sat.enter", 0, 64'h500, 0, 0, 1, 0);
    chk("sat.in_handler", 64'(in_handler), 64'h1);
    model_apply("midreset", 1, 64'h504, 1, 1, 1, 1);
    chk("midreset.cnt", 64'(exc_cnt), 64'h0);
    chk("midreset.in_handler", 64'(in_handler), 64'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
